// File: rtl/dmem_responder.sv
// Far end of the core's data-memory port: a word SRAM bank plus an MMIO page holding
// a console TX FIFO and a free-running compare timer. Reads are registered, one cycle.
module dmem_responder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MEM_WORDS  = 1024,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] dmem_addr,
   input  logic                  dmem_we,
   input  logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  con_valid,
   input  logic                  con_ready,
   output logic [7:0]            con_data,
   output logic                  timer_irq,
   output logic                  bus_err
);
   localparam int unsigned IW = $clog2(MEM_WORDS);
   localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [5:0] {
      OFF_CON_DATA    = 6'h00,
      OFF_CON_STATUS  = 6'h01,
      OFF_TIMER_COUNT = 6'h02,
      OFF_TIMER_CMP   = 6'h03,
      OFF_TIMER_CTRL  = 6'h04
   } mmio_off_e;

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
   logic [7:0]            fifo_q [FIFO_DEPTH];

   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
   logic                  ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0] count_q, count_d, cmp_q, cmp_d;
   logic                  en_q, en_d, pend_q, pend_d;
   logic                  berr_q, berr_d;

   logic                  is_sram, is_mmio, mapped;
   logic [IW-1:0]         sram_idx;
   mmio_off_e             mmio_off;
   logic [DATA_WIDTH-1:0] rd_val;
   logic                  push_req, push, pop, ovf_clr, cnt_wr, cmp_wr, ctrl_wr;
   logic                  full, empty;
   logic [PW-1:0]         occ;
   logic [3:0]            occ_sat;
   logic                  unused_addr;

   assign is_sram     = (dmem_addr[ADDR_WIDTH-1 -: 4] == 4'h0);
   assign is_mmio     = (dmem_addr[ADDR_WIDTH-1 -: 4] == 4'hF);
   assign sram_idx    = dmem_addr[IW+1:2];
   assign mmio_off    = mmio_off_e'(dmem_addr[7:2]);
   assign unused_addr = ^dmem_addr;

   // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
   assign occ   = wptr_q - rptr_q;

   always_comb begin
      if (32'(occ) > 32'd15) occ_sat = 4'hF;
      else                   occ_sat = 4'(occ);
   end

   always_comb begin
      mapped   = 1'b0;
      rd_val   = '0;
      push_req = 1'b0;
      ovf_clr  = 1'b0;
      cnt_wr   = 1'b0;
      cmp_wr   = 1'b0;
      ctrl_wr  = 1'b0;
      if (is_sram) begin
         mapped = 1'b1;
         rd_val = mem_q[sram_idx];
      end else if (is_mmio) begin
         mapped = 1'b1;
         case (mmio_off)
            OFF_CON_DATA:    push_req = dmem_we;
            OFF_CON_STATUS: begin
               rd_val  = {{(DATA_WIDTH-8){1'b0}}, occ_sat, 1'b0, ovf_q, empty, full};
               ovf_clr = dmem_we & dmem_wdata[2];
            end
            OFF_TIMER_COUNT: begin
               rd_val = count_q;
               cnt_wr = dmem_we;
            end
            OFF_TIMER_CMP: begin
               rd_val = cmp_q;
               cmp_wr = dmem_we;
            end
            OFF_TIMER_CTRL: begin
               rd_val  = {{(DATA_WIDTH-2){1'b0}}, pend_q, en_q};
               ctrl_wr = dmem_we;
            end
            default:         mapped = 1'b0;
         endcase
      end
   end

   always_comb begin
      rdata_d = dmem_we ? rdata_q : rd_val;
      berr_d  = berr_q | ~mapped;

      pop    = ~empty & con_ready;
      push   = push_req & ~full;
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(pop);
      ovf_d  = ovf_q;
      if (ovf_clr)         ovf_d = 1'b0;
      if (push_req & full) ovf_d = 1'b1;

      if (cnt_wr)    count_d = dmem_wdata;
      else if (en_q) count_d = count_q + DATA_WIDTH'(1);
      else           count_d = count_q;
      cmp_d = cmp_wr ? dmem_wdata : cmp_q;
      en_d  = ctrl_wr ? dmem_wdata[0] : en_q;
      // A compare hit in the same cycle as a write-1-to-clear leaves pending set.
      pend_d = pend_q;
      if (ctrl_wr & dmem_wdata[1])    pend_d = 1'b0;
      if (en_q && (count_q == cmp_q)) pend_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         ovf_q   <= 1'b0;
         count_q <= '0;
         cmp_q   <= '1;
         en_q    <= 1'b0;
         pend_q  <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         ovf_q   <= ovf_d;
         count_q <= count_d;
         cmp_q   <= cmp_d;
         en_q    <= en_d;
         pend_q  <= pend_d;
         berr_q  <= berr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (dmem_we && is_sram) mem_q[sram_idx] <= dmem_wdata;
      if (push)               fifo_q[wptr_q[PW-2:0]] <= dmem_wdata[7:0];
   end

   assign dmem_rdata = rdata_q;
   assign con_valid  = ~empty;
   assign con_data   = empty ? '0 : fifo_q[rptr_q[PW-2:0]];
   assign timer_irq  = pend_q;
   assign bus_err    = berr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a queue/array reference model predicts every cycle's outputs
// into a scoreboard that a separate monitor drains; directed scenarios plus random traffic.
module tb_dmem_responder;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned MW = 1024;
   localparam int unsigned FD = 8;

   localparam logic [31:0] A_CON_DATA = 32'hF000_0000;
   localparam logic [31:0] A_STATUS   = 32'hF000_0004;
   localparam logic [31:0] A_COUNT    = 32'hF000_0008;
   localparam logic [31:0] A_CMP      = 32'hF000_000C;
   localparam logic [31:0] A_CTRL     = 32'hF000_0010;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] dmem_addr;
   logic          dmem_we;
   logic [DW-1:0] dmem_wdata;
   logic [DW-1:0] dmem_rdata;
   logic          con_valid;
   logic          con_ready;
   logic [7:0]    con_data;
   logic          timer_irq;
   logic          bus_err;

   dmem_responder #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .MEM_WORDS (MW),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dmem_addr (dmem_addr),
      .dmem_we   (dmem_we),
      .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata),
      .con_valid (con_valid),
      .con_ready (con_ready),
      .con_data  (con_data),
      .timer_irq (timer_irq),
      .bus_err   (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned due;
      logic [31:0] rd;
      bit          berr;
      bit          irq;
      bit          cval;
      logic [7:0]  cdata;
   } exp_t;

   exp_t        sb[$];
   exp_t        ce;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   bit [31:0] m_mem [MW];
   bit [7:0]  m_fifo[$];
   bit        m_ovf, m_berr, m_en, m_pend;
   bit [31:0] m_cnt, m_cmp, m_rd;

   task automatic model_step();
      logic [31:0] a, d, rv, cnt_n;
      logic [3:0]  region;
      logic [7:0]  off;
      bit          mapped, push_req, clr, en_pre, hit;
      int          n, sat;
      exp_t        e;
      if (!rst_n) begin
         sb.delete();
         m_fifo.delete();
         m_ovf = 0; m_berr = 0; m_en = 0; m_pend = 0;
         m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_rd = 0;
         return;
      end
      a = dmem_addr;
      d = dmem_wdata;
      region = a[31:28];
      off = a[7:0] & 8'hFC;
      n = m_fifo.size();
      mapped = 1; push_req = 0; clr = 0; rv = 0;
      if (region == 4'h0) rv = m_mem[a[11:2]];
      else if (region == 4'hF) begin
         case (off)
            8'h00: rv = 0;
            8'h04: begin
               sat = (n > 15) ? 15 : n;
               rv = 32'(sat * 16) | (m_ovf ? 32'd4 : 32'd0) | (n == 0 ? 32'd2 : 32'd0)
                  | (n == FD ? 32'd1 : 32'd0);
            end
            8'h08: rv = m_cnt;
            8'h0C: rv = m_cmp;
            8'h10: rv = {30'd0, m_pend, m_en};
            default: mapped = 0;
         endcase
      end else mapped = 0;

      if (!dmem_we) m_rd = rv;
      if (!mapped) m_berr = 1;
      en_pre = m_en;
      hit = m_en && (m_cnt == m_cmp);
      cnt_n = m_en ? m_cnt + 1 : m_cnt;
      if (dmem_we && mapped) begin
         if (region == 4'h0) m_mem[a[11:2]] = d;
         else case (off)
            8'h00: push_req = 1;
            8'h04: if (d[2]) m_ovf = 0;
            8'h08: cnt_n = d;
            8'h0C: m_cmp = d;
            8'h10: begin m_en = d[0]; clr = d[1]; end
            default: ;
         endcase
      end
      if (n > 0 && con_ready) void'(m_fifo.pop_front());
      if (push_req) begin
         if (n < FD) m_fifo.push_back(d[7:0]);
         else m_ovf = 1;
      end
      m_cnt = cnt_n;
      if (clr) m_pend = 0;
      if (en_pre && hit) m_pend = 1;

      e.due   = cyc + 1;
      e.rd    = m_rd;
      e.berr  = m_berr;
      e.irq   = m_pend;
      e.cval  = (m_fifo.size() > 0);
      e.cdata = (m_fifo.size() > 0) ? m_fifo[0] : 8'h00;
      sb.push_back(e);
   endtask

   always @(negedge clk) model_step();

   // Monitor: compare each predicted cycle once the DUT has taken that edge.
   always @(negedge clk) begin
      if (rst_n) begin
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            ce = sb.pop_front();
            chk("sb_rdata", dmem_rdata, ce.rd);
            chk("sb_bus_err", {31'd0, bus_err}, {31'd0, ce.berr});
            chk("sb_timer_irq", {31'd0, timer_irq}, {31'd0, ce.irq});
            chk("sb_con_valid", {31'd0, con_valid}, {31'd0, ce.cval});
            if (ce.cval) chk("sb_con_data", {24'd0, con_data}, {24'd0, ce.cdata});
         end
      end
   end

   task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d);
      dmem_we    = we;
      dmem_addr  = a;
      dmem_wdata = d;
      @(posedge clk);
      #1;
      dmem_we = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      drive(1'b1, a, d);
   endtask

   task automatic rd_expect(input logic [31:0] a, input logic [31:0] exp, input string name);
      drive(1'b0, a, 32'd0);
      chk(name, dmem_rdata, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] ra, rdat;
   logic [7:0]  offs [6];
   int          sel;

   initial begin
      dmem_we = 0; dmem_addr = 0; dmem_wdata = 0; con_ready = 0; rst_n = 0;
      repeat (3) tick();
      chk("rst_rdata", dmem_rdata, 32'd0);
      chk("rst_con_valid", {31'd0, con_valid}, 32'd0);
      chk("rst_con_data", {24'd0, con_data}, 32'd0);
      chk("rst_timer_irq", {31'd0, timer_irq}, 32'd0);
      chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
      rst_n = 1;

      for (int i = 0; i < int'(MW); i++) wr(32'(i * 4), $urandom());

      // SRAM round trip and alias
      wr(32'h0000_0010, 32'hA5A5_0001);
      rd_expect(32'h0000_0010, 32'hA5A5_0001, "sram_rd");
      rd_expect(32'h0000_1010, 32'hA5A5_0001, "sram_alias");

      // Console ordering under backpressure
      wr(A_CON_DATA, 32'h41); wr(A_CON_DATA, 32'h42); wr(A_CON_DATA, 32'h43);
      rd_expect(A_STATUS, 32'h30, "con_status_held");
      con_ready = 1;
      for (int k = 0; k < 3; k++) begin
         chk("con_valid_drain", {31'd0, con_valid}, 32'd1);
         chk("con_order", {24'd0, con_data}, 32'h41 + k);
         tick();
      end
      chk("con_valid_after", {31'd0, con_valid}, 32'd0);
      con_ready = 0;

      // Overflow
      for (int i = 0; i < 9; i++) wr(A_CON_DATA, 32'h50 + i);
      rd_expect(A_STATUS, 32'h85, "ovf_status");
      wr(A_STATUS, 32'h4);
      rd_expect(A_STATUS, 32'h81, "ovf_cleared");
      con_ready = 1;
      for (int k = 0; k < 8; k++) begin
         chk("ovf_order", {24'd0, con_data}, 32'h50 + k);
         tick();
      end
      chk("ovf_ninth_dropped", {31'd0, con_valid}, 32'd0);
      con_ready = 0;

      // Timer compare
      wr(A_CMP, 32'd5); wr(A_COUNT, 32'd0); wr(A_CTRL, 32'd1);
      for (int k = 0; k < 6; k++) begin
         rd_expect(A_COUNT, 32'(k), "timer_count");
         chk("timer_irq_edge", {31'd0, timer_irq}, {31'd0, k == 5});
      end
      wr(A_CTRL, 32'h3);
      chk("timer_irq_clear", {31'd0, timer_irq}, 32'd0);
      rd_expect(A_COUNT, 32'd7, "timer_runs_a");
      rd_expect(A_COUNT, 32'd8, "timer_runs_b");

      // Timer wrap
      wr(A_COUNT, 32'hFFFF_FFFE); wr(A_CTRL, 32'd1);
      rd_expect(A_COUNT, 32'hFFFF_FFFF, "timer_wrap_a");
      rd_expect(A_COUNT, 32'h0000_0000, "timer_wrap_b");

      // Unmapped
      chk("berr_clear", {31'd0, bus_err}, 32'd0);
      rd_expect(32'h4000_0000, 32'd0, "unmapped_rdata");
      chk("berr_set", {31'd0, bus_err}, 32'd1);
      rd_expect(32'hF000_0014, 32'd0, "unmapped_mmio");

      // Random traffic
      offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08;
      offs[3] = 8'h0C; offs[4] = 8'h10; offs[5] = 8'($urandom_range(5, 63) * 4);
      for (int n = 0; n < 3000; n++) begin
         con_ready = 1'($urandom_range(0, 1));
         sel  = $urandom_range(0, 9);
         rdat = $urandom();
         if (sel < 4) ra = {4'h0, 28'($urandom())};
         else if (sel < 9) begin
            offs[5] = 8'($urandom_range(5, 63) * 4);
            ra = {4'hF, 20'($urandom()), offs[$urandom_range(0, 5)] | 8'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) rdat = $urandom_range(0, 31);
         end else ra = {4'($urandom_range(1, 14)), 28'($urandom())};
         drive(1'($urandom_range(0, 1)), ra, rdat);
      end

      // Reset in the middle of a drain
      con_ready = 1;
      repeat (FD + 2) tick();
      con_ready = 0;
      wr(A_CTRL, 32'd0); wr(A_CMP, 32'd0); wr(A_COUNT, 32'd0); wr(A_CTRL, 32'd1);
      for (int i = 0; i < 4; i++) wr(A_CON_DATA, 32'h60 + i);
      drive(1'b0, 32'h4000_0000, 32'd0);
      con_ready = 1;
      tick();
      chk("pre_rst_con_valid", {31'd0, con_valid}, 32'd1);
      chk("pre_rst_irq", {31'd0, timer_irq}, 32'd1);
      chk("pre_rst_berr", {31'd0, bus_err}, 32'd1);
      dmem_addr = A_STATUS;
      #2 rst_n = 0;
      #1;
      chk("async_rst_con_valid", {31'd0, con_valid}, 32'd0);
      chk("async_rst_berr", {31'd0, bus_err}, 32'd0);
      chk("async_rst_irq", {31'd0, timer_irq}, 32'd0);
      chk("async_rst_rdata", dmem_rdata, 32'd0);
      repeat (2) tick();
      rst_n = 1;
      con_ready = 0;
      rd_expect(A_STATUS, 32'h2, "post_rst_status");
      rd_expect(A_CMP, 32'hFFFF_FFFF, "post_rst_cmp");
      rd_expect(A_CTRL, 32'd0, "post_rst_ctrl");
      drive(1'b0, 32'h0000_0010, 32'd0);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
